dm_sba_splitter: RTL

Access sequencer between the debug module's system-bus-access engine and the system bus master port. It accepts one SBA request of up to 128 bits and replays it as one or more aligned bus beats, each at most BusWidth wide. It then assembles read data and reports a single completion. This lifts the 8-byte limit of the SBA engine, and it also converts sub-word accesses into byte-enabled single beats.

---
 rtl/dm_sba_splitter_if.sv | 46 ++++
 rtl/dm_sba_splitter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dm_sba_splitter_if.sv
`default_nettype none
// ============================================================================
// dm_sba_splitter_if
// SBA request/completion and system bus master signals for dm_sba_splitter.
// Revision: 1.0
// ============================================================================
interface dm_sba_splitter_if #(
   parameter int BusWidth = 32
);
   logic                  dmactive_i;
   logic                  req_i;
   logic                  we_i;
   logic [BusWidth-1:0]   addr_i;
   logic [2:0]            size_i;
   logic [127:0]          wdata_i;
   logic                  gnt_o;
   logic                  rvalid_o;
   logic [127:0]          rdata_o;
   logic                  err_o;
   logic                  master_req_o;
   logic [BusWidth-1:0]   master_add_o;
   logic                  master_we_o;
   logic [BusWidth-1:0]   master_wdata_o;
   logic [BusWidth/8-1:0] master_be_o;
   logic                  master_gnt_i;
   logic                  master_r_valid_i;
   logic [BusWidth-1:0]   master_r_rdata_i;
   logic                  master_r_err_i;

   // splitter side: it masters the system bus
   modport master (
      input  dmactive_i, req_i, we_i, addr_i, size_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o, err_o,
      output master_req_o, master_add_o, master_we_o, master_wdata_o, master_be_o,
      input  master_gnt_i, master_r_valid_i, master_r_rdata_i, master_r_err_i
   );

   // SBA engine and bus slave side
   modport slave (
      output dmactive_i, req_i, we_i, addr_i, size_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o, err_o,
      input  master_req_o, master_add_o, master_we_o, master_wdata_o, master_be_o,
      output master_gnt_i, master_r_valid_i, master_r_rdata_i, master_r_err_i
   );
endinterface
`default_nettype wire

// File: rtl/dm_sba_splitter.sv
`default_nettype none
// ============================================================================
// dm_sba_splitter
// Replays one SBA access of up to 128 bits as aligned bus beats and merges reads.
// Revision: 1.0
// ============================================================================
module dm_sba_splitter #(
   parameter int BusWidth = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   dm_sba_splitter_if.master bus
);
   localparam int c_w     = BusWidth / 8;
   localparam int c_lw    = $clog2(c_w);
   localparam int c_beats = 128 / BusWidth;
   localparam int c_bw    = $clog2(c_beats);
   localparam logic [c_w:0]      c_one_w = 1;
   localparam logic [BusWidth:0] c_one_b = 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN
   } state_t;

   state_t                           r_state, w_next;
   logic                             r_we, r_err;
   logic [BusWidth-1:0]              r_addr;
   logic [2:0]                       r_size;
   logic [1:0]                       r_beat;
   logic [c_beats-1:0][BusWidth-1:0] r_wdata, r_acc;

   logic                w_gnt, w_rvalid, w_bad, w_single, w_last, w_req;
   logic [3:0]          w_amask;
   logic [1:0]          w_nm1;
   logic [c_bw-1:0]     w_lane;
   logic [c_lw-1:0]     w_off;
   logic [c_w-1:0]      w_bytemask, w_be;
   logic [BusWidth-1:0] w_bitmask, w_wbeat, w_rbeat;

   assign w_amask  = 4'((5'd1 << bus.size_i) - 5'd1);
   assign w_bad    = (bus.size_i > 3'd4) || ((bus.addr_i[3:0] & w_amask) != 4'd0);
   assign w_lane   = r_beat[c_bw-1:0];
   assign w_off    = r_addr[c_lw-1:0];
   assign w_single = (r_size <= 3'(c_lw));
   assign w_last   = (r_beat == w_nm1);

   always_comb begin
      w_nm1 = 2'd0;
      if (r_size > 3'(c_lw)) begin
         w_nm1 = 2'((3'd1 << (r_size - 3'(c_lw))) - 3'd1);
      end
   end

   // Sub-word accesses move between byte lane 0 and the addressed lane
   assign w_bytemask = c_w'((c_one_w << (1 << r_size)) - c_one_w);
   assign w_bitmask  = BusWidth'((c_one_b << (8 << r_size)) - c_one_b);

   always_comb begin
      w_be    = '1;
      w_wbeat = r_wdata[w_lane];
      w_rbeat = bus.master_r_rdata_i;
      if (w_single) begin
         w_be    = w_bytemask << w_off;
         w_wbeat = r_wdata[0] << {w_off, 3'b000};
         w_rbeat = (bus.master_r_rdata_i >> {w_off, 3'b000}) & w_bitmask;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_gnt    = 1'b0;
      w_rvalid = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_gnt = bus.req_i & bus.dmactive_i;
            if (w_gnt) begin
               w_next = w_bad ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!bus.dmactive_i) begin
               w_next = S_IDLE;
            end else if (bus.master_gnt_i) begin
               w_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!bus.dmactive_i) begin
               w_next = bus.master_r_valid_i ? S_IDLE : S_DRAIN;
            end else if (bus.master_r_valid_i) begin
               w_next = (bus.master_r_err_i || w_last) ? S_DONE : S_ISSUE;
            end
         end
         S_DONE: begin
            w_rvalid = 1'b1;
            w_next   = S_IDLE;
         end
         S_DRAIN: begin
            if (bus.master_r_valid_i) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_size  <= 3'd0;
         r_wdata <= '0;
         r_beat  <= 2'd0;
         r_acc   <= '0;
         r_err   <= 1'b0;
      end else if (w_gnt) begin
         r_we    <= bus.we_i;
         r_addr  <= bus.addr_i;
         r_size  <= bus.size_i;
         r_wdata <= bus.wdata_i;
         r_beat  <= 2'd0;
         r_acc   <= '0;
         r_err   <= w_bad;
      end else if (r_state == S_WAIT && bus.dmactive_i && bus.master_r_valid_i) begin
         if (!r_we) begin
            r_acc[w_lane] <= w_rbeat;
         end
         r_err <= r_err | bus.master_r_err_i;
         if (!(bus.master_r_err_i || w_last)) begin
            r_beat <= r_beat + 2'd1;
         end
      end
   end

   // Request withdraws in the same cycle the debug module goes inactive
   assign w_req              = (r_state == S_ISSUE) && bus.dmactive_i;
   assign bus.master_req_o   = w_req;
   assign bus.master_add_o   = w_req ? r_addr + (BusWidth'(r_beat) << c_lw) : '0;
   assign bus.master_we_o    = w_req & r_we;
   assign bus.master_wdata_o = w_req ? w_wbeat : '0;
   assign bus.master_be_o    = w_req ? w_be : '0;

   assign bus.gnt_o    = w_gnt;
   assign bus.rvalid_o = w_rvalid;
   assign bus.err_o    = r_err;
   assign bus.rdata_o  = r_err ? '0 : r_acc;
endmodule
`default_nettype wire
